// File: rtl/store_queue_pkg.sv
// Shared types and constants for the store queue: entry layout, drain FSM encoding, default depth.
package store_queue_pkg;

  localparam int SQ_DEPTH = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  size;
  } store_queue_entry_t;

  typedef enum logic [1:0] {
    SQ_IDLE = 2'd0,
    SQ_REQ  = 2'd1,
    SQ_WAIT = 2'd2
  } sq_state_t;

  // Raw encodings used by the drain FSM register; kept equal to sq_state_t.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

endpackage

// File: rtl/store_queue_if.sv
// Store queue bus bundle: AGU push port, commit strobes, flush, DCache write port, status.
// Forwarding signals exist only when STORE_QUEUE_FWD_EN is defined.
interface store_queue_if #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
);
  // Push transfers on a cycle where push_valid && push_ready && !flush; push_ready never
  // depends on push_valid. The DCache request is held stable until dcache_addr_ok.
  logic               flush;
  logic               push_valid;
  logic               push_ready;
  logic [31:0]        push_addr;
  logic [31:0]        push_wdata;
  logic [3:0]         push_wstrb;
  logic [2:0]         push_size;
  logic               commit_store1_valid;
  logic               commit_store2_valid;
  logic               dcache_req;
  logic               dcache_wr;
  logic [3:0]         dcache_wstrb;
  logic [2:0]         dcache_size;
  logic [31:0]        dcache_addr;
  logic [31:0]        dcache_wdata;
  logic               dcache_addr_ok;
  logic               dcache_data_ok;
  logic               sq_empty;
  logic [PTR_W:0]     sq_committed_cnt;
`ifdef STORE_QUEUE_FWD_EN
  logic [31:0]        fwd_addr;
  logic [3:0]         fwd_wstrb;
  logic               fwd_hit;
  logic [31:0]        fwd_data;

  modport slave (
    input  flush, push_valid, push_addr, push_wdata, push_wstrb, push_size,
    input  commit_store1_valid, commit_store2_valid, dcache_addr_ok, dcache_data_ok,
    input  fwd_addr, fwd_wstrb,
    output push_ready, dcache_req, dcache_wr, dcache_wstrb, dcache_size, dcache_addr,
    output dcache_wdata, sq_empty, sq_committed_cnt, fwd_hit, fwd_data
  );
  modport master (
    output flush, push_valid, push_addr, push_wdata, push_wstrb, push_size,
    output commit_store1_valid, commit_store2_valid, dcache_addr_ok, dcache_data_ok,
    output fwd_addr, fwd_wstrb,
    input  push_ready, dcache_req, dcache_wr, dcache_wstrb, dcache_size, dcache_addr,
    input  dcache_wdata, sq_empty, sq_committed_cnt, fwd_hit, fwd_data
  );
`else
  modport slave (
    input  flush, push_valid, push_addr, push_wdata, push_wstrb, push_size,
    input  commit_store1_valid, commit_store2_valid, dcache_addr_ok, dcache_data_ok,
    output push_ready, dcache_req, dcache_wr, dcache_wstrb, dcache_size, dcache_addr,
    output dcache_wdata, sq_empty, sq_committed_cnt
  );
  modport master (
    output flush, push_valid, push_addr, push_wdata, push_wstrb, push_size,
    output commit_store1_valid, commit_store2_valid, dcache_addr_ok, dcache_data_ok,
    input  push_ready, dcache_req, dcache_wr, dcache_wstrb, dcache_size, dcache_addr,
    input  dcache_wdata, sq_empty, sq_committed_cnt
  );
`endif
endinterface

// File: rtl/sq_fwd_match.sv
// Age-ordered forwarding search over live store queue entries (head..tail-1), youngest match wins.
// Compiled only when STORE_QUEUE_FWD_EN is defined.
`ifdef STORE_QUEUE_FWD_EN
module sq_fwd_match
  import store_queue_pkg::*;
#(
  parameter int DEPTH = SQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  store_queue_entry_t entries [DEPTH],
  input  logic [PTR_W-1:0]   head,
  input  logic [PTR_W:0]     count,
  input  logic [31:0]        fwd_addr,
  input  logic [3:0]         fwd_wstrb,
  output logic               fwd_hit,
  output logic [31:0]        fwd_data
);
  localparam int PW = PTR_W + 1;

  logic             found;
  logic [PTR_W-1:0] sel;
  logic [PTR_W-1:0] idx;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (PW'(i) < count && entries[idx].addr[31:2] == fwd_addr[31:2]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    // A younger partial overlap shadows older full matches: the load must wait.
    fwd_hit  = found && (entries[sel].wstrb == fwd_wstrb);
    fwd_data = entries[sel].wdata;
  end
endmodule
`endif

// File: rtl/store_queue.sv
// Circular store queue between AGU and DCache: speculative push, in-order commit and drain,
// flush of uncommitted entries. Optional store-to-load forwarding under STORE_QUEUE_FWD_EN.
module store_queue
  import store_queue_pkg::*;
#(
  parameter int DEPTH = SQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  store_queue_if.slave sq,
  output sq_state_t    sq_state
);
  localparam int PW = PTR_W + 1;

  logic [PTR_W:0]     head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
  logic [1:0]         state_q, state_d;
  store_queue_entry_t mem_q [DEPTH];
  store_queue_entry_t head_entry;
  logic [PTR_W:0]     occupancy, uncommitted, cmt_adv, head_inc;
  logic [1:0]         commit_n;
  logic               push_fire, pop;

  assign occupancy     = tail_q - head_q;
  assign sq.push_ready = occupancy != PW'(DEPTH);
  assign push_fire     = sq.push_valid && sq.push_ready && !sq.flush;
  assign commit_n      = {1'b0, sq.commit_store1_valid} + {1'b0, sq.commit_store2_valid};
  assign uncommitted   = tail_q - cmt_q;
  assign head_inc      = head_q + PW'(1);

  always_comb begin
    cmt_adv = (PW'(commit_n) < uncommitted) ? PW'(commit_n) : uncommitted;
    cmt_d   = cmt_q + cmt_adv;
    // Flush keeps everything committed, including commits landing this very cycle.
    tail_d  = sq.flush ? cmt_d : tail_q + PW'(push_fire);
    pop     = 1'b0;
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmt_d != head_q) state_d = ST_REQ;
      ST_REQ: begin
        if (sq.dcache_addr_ok) begin
          state_d = ST_WAIT;
          pop     = sq.dcache_data_ok;
        end
      end
      ST_WAIT: pop = sq.dcache_data_ok;
      default: state_d = ST_IDLE;
    endcase
    if (pop) state_d = (cmt_d != head_inc) ? ST_REQ : ST_IDLE;
    head_d = pop ? head_inc : head_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      cmt_q   <= '0;
      tail_q  <= '0;
      state_q <= ST_IDLE;
    end else begin
      head_q  <= head_d;
      cmt_q   <= cmt_d;
      tail_q  <= tail_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_q[tail_q[PTR_W-1:0]] <= '{addr:  sq.push_addr,  wdata: sq.push_wdata,
                                    wstrb: sq.push_wstrb, size:  sq.push_size};
    end
  end

  assign head_entry          = mem_q[head_q[PTR_W-1:0]];
  assign sq.dcache_req       = (state_q == ST_REQ);
  assign sq.dcache_wr        = (state_q == ST_REQ);
  assign sq.dcache_addr      = head_entry.addr;
  assign sq.dcache_wdata     = head_entry.wdata;
  assign sq.dcache_wstrb     = head_entry.wstrb;
  assign sq.dcache_size      = head_entry.size;
  assign sq.sq_empty         = (head_q == tail_q);
  assign sq.sq_committed_cnt = cmt_q - head_q;
  assign sq_state            = sq_state_t'(state_q);

  // Commit retiring more stores than are pending is a pipeline bug; the advance is clamped.
  a_no_overcommit: assert property (@(posedge clk) disable iff (reset)
    PW'(commit_n) <= uncommitted);

`ifdef STORE_QUEUE_FWD_EN
  sq_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd (
    .entries   (mem_q),
    .head      (head_q[PTR_W-1:0]),
    .count     (occupancy),
    .fwd_addr  (sq.fwd_addr),
    .fwd_wstrb (sq.fwd_wstrb),
    .fwd_hit   (sq.fwd_hit),
    .fwd_data  (sq.fwd_data)
  );
`endif

endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: directed scenarios plus randomized traffic against a queue-level model.
// Forwarding scenario is compiled when STORE_QUEUE_FWD_EN is defined.
module tb_store_queue;
  import store_queue_pkg::*;

  localparam int DEPTH = 8;

  logic      clk = 1'b0;
  logic      reset;
  sq_state_t sq_state;
  int        vectors = 0;
  int        miscompares = 0;

  // Model: live entries oldest-first {size, wstrb, addr, data}; mdl_cmt = committed count.
  logic [70:0] mdl_q[$];
  int          mdl_cmt = 0;
  bit          outstanding = 0;
  // Scoreboard: {valid, size, wstrb, addr, data} per accepted DCache request.
  logic [71:0] exp_q[$];
  logic [71:0] obs_q[$];

  store_queue_if #(.DEPTH(DEPTH)) sq_if ();

  store_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .sq       (sq_if),
    .sq_state (sq_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic drive_cycle(input bit pv, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [2:0] sz, input bit c1,
                             input bit c2, input bit fl, input bit ao, input bit dok);
    int n, adv, keep;
    bit fire, pop, req_pre;
    sq_if.push_valid = pv;  sq_if.push_addr = a;  sq_if.push_wdata = d;
    sq_if.push_wstrb = s;   sq_if.push_size = sz;
    sq_if.commit_store1_valid = c1;  sq_if.commit_store2_valid = c2;
    sq_if.flush = fl;  sq_if.dcache_addr_ok = ao;  sq_if.dcache_data_ok = dok;
    n    = int'(c1) + int'(c2);
    adv  = (n < mdl_q.size() - mdl_cmt) ? n : mdl_q.size() - mdl_cmt;
    fire = pv && (mdl_q.size() != DEPTH) && !fl;
    req_pre = sq_if.dcache_req;
    pop  = dok && (outstanding || (req_pre && ao));
    if (req_pre && ao) begin
      obs_q.push_back({1'b1, sq_if.dcache_size, sq_if.dcache_wstrb, sq_if.dcache_addr,
                       sq_if.dcache_wdata});
      exp_q.push_back((mdl_cmt > 0) ? {1'b1, mdl_q[0]} : 72'h0);
    end
    @(posedge clk);
    #1;
    keep = mdl_cmt + adv;
    if (fl) begin
      while (mdl_q.size() > keep) void'(mdl_q.pop_back());
    end else if (fire) begin
      mdl_q.push_back({sz, s, a, d});
    end
    mdl_cmt = keep;
    if (pop && mdl_q.size() > 0 && mdl_cmt > 0) begin
      void'(mdl_q.pop_front());
      mdl_cmt--;
    end
    if (pop) outstanding = 0;
    else if (req_pre && ao) outstanding = 1;
  endtask

  task automatic idle_cycle();
    drive_cycle(0, 32'h0, 32'h0, 4'h0, 3'd0, 0, 0, 0, 0, 0);
  endtask

  // Acts as the DCache with random acceptance/completion until the model has nothing left.
  task automatic drain_all(output bit timed_out);
    bit ao, dok;
    timed_out = 1;
    for (int i = 0; i < 400; i++) begin
      if (mdl_q.size() == 0 && !outstanding) begin
        timed_out = 0;
        break;
      end
      ao  = sq_if.dcache_req && ($urandom_range(0, 3) != 0);
      dok = (outstanding || ao) && ($urandom_range(0, 2) != 0);
      drive_cycle(0, 32'h0, 32'h0, 4'h0, 3'd0, 0, 0, 0, ao, dok);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mdl_q.delete(); mdl_cmt = 0; outstanding = 0; exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (sq_if.dcache_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", sq_if.dcache_req); end
    vectors++; if (sq_if.dcache_wr !== 1'b0) begin miscompares++; $display("FAIL reset_wr: got %b want 0", sq_if.dcache_wr); end
    vectors++; if (sq_if.sq_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", sq_if.sq_empty); end
    vectors++; if (sq_if.sq_committed_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", sq_if.sq_committed_cnt); end
    vectors++; if (sq_if.push_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", sq_if.push_ready); end
    reset = 1'b0;
    mdl_q.delete(); mdl_cmt = 0; outstanding = 0;
  endtask

  task automatic test_single();
    logic [71:0] o, e;
    drive_cycle(1, 32'h1000, 32'hDEADBEEF, 4'hF, 3'd2, 0, 0, 0, 0, 0);
    vectors++; if (sq_if.sq_empty !== 1'b0) begin miscompares++; $display("FAIL single_empty: got %b want 0", sq_if.sq_empty); end
    vectors++; if (sq_if.dcache_req !== 1'b0) begin miscompares++; $display("FAIL single_early_req: got %b want 0", sq_if.dcache_req); end
    drive_cycle(0, 32'h0, 32'h0, 4'h0, 3'd0, 1, 0, 0, 0, 0);
    vectors++; if (sq_if.dcache_req !== 1'b1) begin miscompares++; $display("FAIL single_req: got %b want 1", sq_if.dcache_req); end
    vectors++; if (sq_if.dcache_wr !== 1'b1) begin miscompares++; $display("FAIL single_wr: got %b want 1", sq_if.dcache_wr); end
    vectors++; if (sq_if.dcache_addr !== 32'h1000) begin miscompares++; $display("FAIL single_addr: got %h want 00001000", sq_if.dcache_addr); end
    vectors++; if (sq_if.sq_committed_cnt !== 4'd1) begin miscompares++; $display("FAIL single_cnt: got %0d want 1", sq_if.sq_committed_cnt); end
    idle_cycle();
    vectors++; if (sq_if.dcache_req !== 1'b1) begin miscompares++; $display("FAIL single_req_hold: got %b want 1", sq_if.dcache_req); end
    drive_cycle(0, 32'h0, 32'h0, 4'h0, 3'd0, 0, 0, 0, 1, 0);
    vectors++; if (sq_if.dcache_req !== 1'b0) begin miscompares++; $display("FAIL single_wait_req: got %b want 0", sq_if.dcache_req); end
    vectors++; if (sq_state !== SQ_WAIT) begin miscompares++; $display("FAIL single_wait_state: got %0d want %0d", sq_state, SQ_WAIT); end
    vectors++; if (sq_if.sq_empty !== 1'b0) begin miscompares++; $display("FAIL single_wait_empty: got %b want 0", sq_if.sq_empty); end
    drive_cycle(0, 32'h0, 32'h0, 4'h0, 3'd0, 0, 0, 0, 0, 1);
    vectors++; if (sq_if.sq_empty !== 1'b1) begin miscompares++; $display("FAIL single_done_empty: got %b want 1", sq_if.sq_empty); end
    vectors++; if (sq_if.dcache_req !== 1'b0) begin miscompares++; $display("FAIL single_done_req: got %b want 0", sq_if.dcache_req); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL single_write: got %h want %h", o, e); end
    end
  endtask

  task automatic test_commit_flush();
    logic [71:0] o, e;
    bit to;
    int writes;
    for (int i = 0; i < 3; i++) drive_cycle(1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 3'd2, 0, 0, 0, 0, 0);
    drive_cycle(1, 32'h10C, 32'hAF, 4'hF, 3'd2, 1, 1, 1, 0, 0);
    vectors++; if (sq_if.sq_committed_cnt !== 4'd2) begin miscompares++; $display("FAIL flush_cnt: got %0d want 2", sq_if.sq_committed_cnt); end
    vectors++; if (sq_if.sq_empty !== 1'b0) begin miscompares++; $display("FAIL flush_empty: got %b want 0", sq_if.sq_empty); end
    drain_all(to);
    vectors++; if (to) begin miscompares++; $display("FAIL flush_drain_timeout: got timeout want drained"); end
    vectors++; if (sq_if.sq_empty !== 1'b1) begin miscompares++; $display("FAIL flush_after_empty: got %b want 1", sq_if.sq_empty); end
    repeat (4) idle_cycle();
    vectors++; if (sq_if.dcache_req !== 1'b0) begin miscompares++; $display("FAIL flush_extra_req: got %b want 0", sq_if.dcache_req); end
    writes = obs_q.size();
    vectors++; if (writes != 2) begin miscompares++; $display("FAIL flush_writes: got %0d want 2", writes); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL flush_write: got %h want %h", o, e); end
    end
  endtask

  task automatic test_full();
    logic [71:0] o, e;
    bit to;
    int writes;
    for (int i = 0; i < DEPTH; i++) drive_cycle(1, 32'h400 + 32'(4 * i), 32'h50 + 32'(i), 4'hF, 3'd2, 0, 0, 0, 0, 0);
    vectors++; if (sq_if.push_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b want 0", sq_if.push_ready); end
    drive_cycle(1, 32'hBAD0, 32'hBAD, 4'hF, 3'd2, 0, 0, 0, 0, 0);
    vectors++; if (sq_if.push_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_9th: got %b want 0", sq_if.push_ready); end
    repeat (4) drive_cycle(0, 32'h0, 32'h0, 4'h0, 3'd0, 1, 1, 0, 0, 0);
    vectors++; if (sq_if.sq_committed_cnt !== 4'd8) begin miscompares++; $display("FAIL full_cnt: got %0d want 8", sq_if.sq_committed_cnt); end
    drive_cycle(0, 32'h0, 32'h0, 4'h0, 3'd0, 0, 0, 0, 1, 0);
    vectors++; if (sq_if.push_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_wait: got %b want 0", sq_if.push_ready); end
    drive_cycle(0, 32'h0, 32'h0, 4'h0, 3'd0, 0, 0, 0, 0, 1);
    vectors++; if (sq_if.push_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_after_pop: got %b want 1", sq_if.push_ready); end
    vectors++; if (sq_if.sq_committed_cnt !== 4'd7) begin miscompares++; $display("FAIL full_cnt_after_pop: got %0d want 7", sq_if.sq_committed_cnt); end
    drain_all(to);
    vectors++; if (to) begin miscompares++; $display("FAIL full_drain_timeout: got timeout want drained"); end
    vectors++; if (sq_if.sq_empty !== 1'b1) begin miscompares++; $display("FAIL full_after_empty: got %b want 1", sq_if.sq_empty); end
    writes = obs_q.size();
    vectors++; if (writes != 8) begin miscompares++; $display("FAIL full_writes: got %0d want 8", writes); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL full_write: got %h want %h", o, e); end
    end
  endtask

  task automatic test_wrap();
    logic [71:0] o, e;
    bit to;
    int k = 0;
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        vectors++; if (sq_if.push_ready !== 1'b1) begin miscompares++; $display("FAIL wrap_ready: got %b want 1 round %0d", sq_if.push_ready, r); end
        drive_cycle(1, 32'h8000 + 32'(4 * (r * DEPTH + i)), 32'(r * DEPTH + i), 4'hF, 3'd2, 0, 0, 0, 0, 0);
      end
      repeat (DEPTH / 2) drive_cycle(0, 32'h0, 32'h0, 4'h0, 3'd0, 1, 1, 0, 0, 0);
      drain_all(to);
      vectors++; if (to) begin miscompares++; $display("FAIL wrap_drain_timeout: got timeout want drained round %0d", r); end
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front(); e = exp_q.pop_front();
        vectors++; if (o !== e || o[31:0] !== 32'(k)) begin miscompares++; $display("FAIL wrap_write: got %h want %h data %0d", o, e, k); end
        k++;
      end
    end
    vectors++; if (k != 128) begin miscompares++; $display("FAIL wrap_total: got %0d want 128", k); end
  endtask

  task automatic test_random();
    logic [71:0] o, e;
    bit to, pv, c1, c2, fl, ao, dok;
    int avail;
    for (int cyc = 0; cyc < 800; cyc++) begin
      vectors++; if (sq_if.push_ready !== (mdl_q.size() != DEPTH)) begin miscompares++; $display("FAIL rand_ready: got %b want %b cyc %0d", sq_if.push_ready, mdl_q.size() != DEPTH, cyc); end
      vectors++; if (sq_if.sq_empty !== (mdl_q.size() == 0)) begin miscompares++; $display("FAIL rand_empty: got %b want %b cyc %0d", sq_if.sq_empty, mdl_q.size() == 0, cyc); end
      vectors++; if (sq_if.sq_committed_cnt !== 4'(mdl_cmt)) begin miscompares++; $display("FAIL rand_cnt: got %0d want %0d cyc %0d", sq_if.sq_committed_cnt, mdl_cmt, cyc); end
      vectors++; if (sq_if.dcache_wr !== sq_if.dcache_req) begin miscompares++; $display("FAIL rand_wr: got %b want %b", sq_if.dcache_wr, sq_if.dcache_req); end
      if (sq_if.dcache_req === 1'b1) begin
        vectors++; if (mdl_cmt == 0) begin miscompares++; $display("FAIL rand_req_uncommitted: got req=1 want req=0 cyc %0d", cyc); end
      end
      pv    = $urandom_range(0, 2) != 0;
      avail = mdl_q.size() - mdl_cmt;
      c1    = $urandom_range(0, 1) == 1;
      c2    = $urandom_range(0, 1) == 1;
      if (avail == 0) begin c1 = 0; c2 = 0; end
      else if (avail == 1 && c1 && c2) c1 = 0;
      fl  = $urandom_range(0, 19) == 0;
      ao  = sq_if.dcache_req && ($urandom_range(0, 1) == 1);
      dok = (outstanding || ao) && ($urandom_range(0, 1) == 1);
      drive_cycle(pv, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom, 4'($urandom_range(1, 15)),
                  3'($urandom_range(0, 2)), c1, c2, fl, ao, dok);
    end
    while (mdl_cmt < mdl_q.size())
      drive_cycle(0, 32'h0, 32'h0, 4'h0, 3'd0, 1, (mdl_q.size() - mdl_cmt) >= 2, 0, 0, 0);
    drain_all(to);
    vectors++; if (to) begin miscompares++; $display("FAIL rand_drain_timeout: got timeout want drained"); end
    vectors++; if (sq_if.sq_empty !== 1'b1) begin miscompares++; $display("FAIL rand_final_empty: got %b want 1", sq_if.sq_empty); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL rand_write: got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_wait();
    logic [71:0] o, e;
    bit to;
    drive_cycle(1, 32'h3000, 32'h33, 4'hF, 3'd2, 0, 0, 0, 0, 0);
    drive_cycle(0, 32'h0, 32'h0, 4'h0, 3'd0, 1, 0, 0, 0, 0);
    drive_cycle(0, 32'h0, 32'h0, 4'h0, 3'd0, 0, 0, 0, 1, 0);
    vectors++; if (sq_state !== SQ_WAIT) begin miscompares++; $display("FAIL rstw_state: got %0d want %0d", sq_state, SQ_WAIT); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL rstw_write: got %h want %h", o, e); end
    end
    reset = 1'b1;
    #1;
    vectors++; if (sq_if.dcache_req !== 1'b0) begin miscompares++; $display("FAIL rstw_req: got %b want 0", sq_if.dcache_req); end
    vectors++; if (sq_if.sq_empty !== 1'b1) begin miscompares++; $display("FAIL rstw_empty: got %b want 1", sq_if.sq_empty); end
    vectors++; if (sq_if.sq_committed_cnt !== 4'd0) begin miscompares++; $display("FAIL rstw_cnt: got %0d want 0", sq_if.sq_committed_cnt); end
    vectors++; if (sq_state !== SQ_IDLE) begin miscompares++; $display("FAIL rstw_idle: got %0d want %0d", sq_state, SQ_IDLE); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    mdl_q.delete(); mdl_cmt = 0; outstanding = 0;
    drive_cycle(0, 32'h0, 32'h0, 4'h0, 3'd0, 0, 0, 0, 0, 1);
    vectors++; if (sq_if.sq_empty !== 1'b1) begin miscompares++; $display("FAIL rstw_late_empty: got %b want 1", sq_if.sq_empty); end
    vectors++; if (sq_if.dcache_req !== 1'b0) begin miscompares++; $display("FAIL rstw_late_req: got %b want 0", sq_if.dcache_req); end
    vectors++; if (sq_if.push_ready !== 1'b1) begin miscompares++; $display("FAIL rstw_late_ready: got %b want 1", sq_if.push_ready); end
    drive_cycle(1, 32'h3400, 32'h34, 4'h3, 3'd1, 0, 0, 0, 0, 0);
    drive_cycle(0, 32'h0, 32'h0, 4'h0, 3'd0, 0, 1, 0, 0, 0);
    vectors++; if (sq_if.dcache_req !== 1'b1 || sq_if.dcache_addr !== 32'h3400) begin miscompares++; $display("FAIL rstw_restart: got req=%b addr=%h want req=1 addr=00003400", sq_if.dcache_req, sq_if.dcache_addr); end
    drain_all(to);
    vectors++; if (to) begin miscompares++; $display("FAIL rstw_drain_timeout: got timeout want drained"); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL rstw_write2: got %h want %h", o, e); end
    end
  endtask

`ifdef STORE_QUEUE_FWD_EN
  task automatic test_fwd();
    bit to;
    drive_cycle(1, 32'h2000, 32'h11, 4'hF, 3'd2, 0, 0, 0, 0, 0);
    drive_cycle(1, 32'h2000, 32'h22, 4'hF, 3'd2, 0, 0, 0, 0, 0);
    drive_cycle(1, 32'h2004, 32'h44, 4'h3, 3'd1, 0, 0, 0, 0, 0);
    sq_if.fwd_addr = 32'h2000; sq_if.fwd_wstrb = 4'hF; #1;
    vectors++; if (sq_if.fwd_hit !== 1'b1 || sq_if.fwd_data !== 32'h22) begin miscompares++; $display("FAIL fwd_youngest: got hit=%b data=%h want hit=1 data=00000022", sq_if.fwd_hit, sq_if.fwd_data); end
    sq_if.fwd_addr = 32'h2004; sq_if.fwd_wstrb = 4'h1; #1;
    vectors++; if (sq_if.fwd_hit !== 1'b0) begin miscompares++; $display("FAIL fwd_partial: got hit=%b want 0", sq_if.fwd_hit); end
    sq_if.fwd_wstrb = 4'h3; #1;
    vectors++; if (sq_if.fwd_hit !== 1'b1 || sq_if.fwd_data !== 32'h44) begin miscompares++; $display("FAIL fwd_exact: got hit=%b data=%h want hit=1 data=00000044", sq_if.fwd_hit, sq_if.fwd_data); end
    sq_if.fwd_addr = 32'h2008; sq_if.fwd_wstrb = 4'hF; #1;
    vectors++; if (sq_if.fwd_hit !== 1'b0) begin miscompares++; $display("FAIL fwd_miss: got hit=%b want 0", sq_if.fwd_hit); end
    drive_cycle(0, 32'h0, 32'h0, 4'h0, 3'd0, 1, 1, 0, 0, 0);
    drive_cycle(0, 32'h0, 32'h0, 4'h0, 3'd0, 1, 0, 0, 0, 0);
    drain_all(to);
    vectors++; if (to) begin miscompares++; $display("FAIL fwd_drain_timeout: got timeout want drained"); end
    obs_q.delete(); exp_q.delete();
  endtask
`endif

  initial begin
    reset = 1'b1;
    sq_if.flush = 0; sq_if.push_valid = 0; sq_if.push_addr = '0; sq_if.push_wdata = '0;
    sq_if.push_wstrb = '0; sq_if.push_size = '0; sq_if.commit_store1_valid = 0;
    sq_if.commit_store2_valid = 0; sq_if.dcache_addr_ok = 0; sq_if.dcache_data_ok = 0;
`ifdef STORE_QUEUE_FWD_EN
    sq_if.fwd_addr = '0; sq_if.fwd_wstrb = '0;
`endif
    test_reset();
    test_single();
    test_commit_flush();
    test_full();
    test_wrap();
    test_random();
    test_reset_wait();
`ifdef STORE_QUEUE_FWD_EN
    apply_reset();
    test_fwd();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
- Circular queue of store operations, between the AGU store path in the execute stage and the DCache data port.
- AGU pushes each store speculatively once its address is translated.
- Commit marks the oldest stores as retired through commit_store1_valid / commit_store2_valid.
- Retired stores drain to the DCache in order, one outstanding request at a time; flush discards only speculative entries.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 4.
- PTR_W, $clog2(DEPTH), index width; pointers carry one extra wrap bit.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush; drop uncommitted entries
- push_valid  in  1  AGU presents a translated store
- push_ready  out  1  queue can accept a push this cycle
- push_addr  in  32  physical byte address
- push_wdata  in  32  store data, already lane-aligned
- push_wstrb  in  4  byte enables
- push_size  in  3  access size, passed through to the DCache
- commit_store1_valid  in  1  commit retires one store (slot 1)
- commit_store2_valid  in  1  commit retires one store (slot 2)
- dcache_req  out  1  write request valid
- dcache_wr  out  1  constant 1 while dcache_req is high, else 0
- dcache_wstrb  out  4  head entry byte enables
- dcache_size  out  3  head entry size
- dcache_addr  out  32  head entry address
- dcache_wdata  out  32  head entry data
- dcache_addr_ok  in  1  DCache accepted the request
- dcache_data_ok  in  1  DCache completed the write
- sq_empty  out  1  no entries held (committed or speculative)
- sq_committed_cnt  out  PTR_W+1  number of committed, not-yet-drained entries

Behaviour:
- Pointers, each PTR_W+1 bits, full/empty decided by comparing the wrap bit:
  - head: oldest entry.
  - cmt: first uncommitted entry.
  - tail: next free slot.
  - Ordering invariant: head <= cmt <= tail (modulo wrap).
- Reset (async): head = cmt = tail = 0; FSM = IDLE. Reset values: dcache_req = 0, dcache_wr = 0, sq_empty = 1, sq_committed_cnt = 0. Entry storage is not reset. Reset mid-transaction abandons the outstanding write.
- push_ready = (tail - head) != DEPTH.
  - Push fires when push_valid && push_ready && !flush.
  - On a push, the entry is written at tail and tail advances by 1.
  - The pushed entry is visible to the drain logic the next cycle.
- Commit:
  - n = commit_store1_valid + commit_store2_valid (0..2). Slot 2 alone counts as 1.
  - cmt advances by min(n, tail - cmt). Over-commit is clamped, and an assertion flags it in simulation.
  - A push in the same cycle does not count toward the clamp.
- Flush:
  - tail <= cmt + commit advance of this cycle, so commits in the flush cycle survive.
  - A push in the flush cycle is dropped.
  - Committed entries and the FSM are unaffected.
- Drain FSM:
  - IDLE: if cmt != head, go to REQ next cycle.
  - REQ: dcache_req = 1 with the head entry fields held stable. On dcache_addr_ok, go to WAIT.
  - WAIT: dcache_req = 0. On dcache_data_ok, head++. Then go to REQ if (cmt != head+1), else IDLE.
  - dcache_data_ok arriving in REQ (same cycle as addr_ok) is accepted: head++, then the same next-state rule as WAIT.
- Latency:
  - Committed entry with FSM idle: dcache_req rises 1 cycle after cmt moves past it.
  - Back-to-back drains: a new request issues the cycle after data_ok.
- Simultaneous push, commit and pop in one cycle are all legal; each pointer updates independently.
- When full, push_ready = 0 until a pop. A pop frees the slot the next cycle; there is no same-cycle bypass.
- sq_empty = (head == tail). sq_committed_cnt = cmt - head.

Optional Feature:
- Macro: STORE_QUEUE_FWD_EN.
- When defined, three extra ports are added:
  - fwd_addr  in  32
  - fwd_hit  out  1
  - fwd_data  out  32
- Forwarding is combinational. It scans all entries from head to tail and compares addr[31:2]. The youngest matching entry wins, provided its wstrb equals the load byte mask. That mask is supplied on an added input fwd_wstrb  in  4.
  - fwd_hit = 1 with that entry's data.
  - A partial overlap gives fwd_hit = 0, and the load must wait for the queue to drain.
- When undefined, the ports and logic are absent.

Decomposition:
- cpu.svh gains:
  - store_queue_entry_t: addr, wdata, wstrb, size.
  - sq_state_t: enum IDLE, REQ, WAIT.
  - constant SQ_DEPTH = 8.
- One sub-module, sq_fwd_match: priority age-ordered match for the forwarding search, instantiated only under STORE_QUEUE_FWD_EN.

Test Plan:
- Push A (addr 0x1000, data 0xDEADBEEF, wstrb 4'hF), commit1 next cycle, addr_ok and data_ok after 2 cycles:
  - dcache_req rises the cycle after the commit, with dcache_addr = 0x1000.
  - sq_empty = 1 after data_ok.
- Push 3 stores, commit_store1 and commit_store2 in the same cycle, then flush:
  - sq_committed_cnt = 2 and the third entry is gone (tail - head = 2).
  - Exactly 2 writes reach the DCache.
- Fill 8 entries:
  - push_ready = 0 and a 9th push is ignored.
  - After the first data_ok, push_ready returns to 1 the next cycle.
- Push 8 stores 16 times (wrap): commit and drain data 0..127 in order, with no reordering or loss.
- Assert reset while in WAIT: dcache_req = 0 immediately, all pointers reach 0, and a late data_ok is ignored.
- With STORE_QUEUE_FWD_EN defined:
  - Push 0x2000 with data 0x11, then 0x2000 with data 0x22, both wstrb 4'hF.
  - fwd_addr 0x2000 with fwd_wstrb 4'hF gives hit = 1 and data 0x22.
  - fwd_wstrb 4'h1 against a wstrb 4'h3 entry gives hit = 0.
